// File: rtl/axi4ls2hpi_adp.sv
// AXI4-Lite slave to HPI register-bus adapter: buffers AW/W/AR, arbitrates one
// transaction at a time into a single cpu_wr/cpu_rd strobe, returns B/R with read timeout.
module axi4ls2hpi_adp #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DATA_BYTE_NUM = DATA_WIDTH / 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  // write address
  input  logic                     awvalid,
  input  logic [ADDR_WIDTH-1:0]    awaddr,
  output logic                     awready,
  // write data
  input  logic                     wvalid,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [DATA_BYTE_NUM-1:0] wstrb,
  output logic                     wready,
  // write response
  output logic                     bvalid,
  output logic [1:0]               bresp,
  input  logic                     bready,
  // read address
  input  logic                     arvalid,
  input  logic [ADDR_WIDTH-1:0]    araddr,
  output logic                     arready,
  // read data
  output logic                     rvalid,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [1:0]               rresp,
  input  logic                     rready,
  // timeout control
  input  logic [15:0]              reg_tmout_cfg,
  output logic                     reg_tmout_err,
  // HPI side
  output logic                     cpu_wr,
  output logic [ADDR_WIDTH-1:0]    cpu_wr_addr,
  output logic [DATA_BYTE_NUM-1:0] cpu_wr_strb,
  output logic [DATA_WIDTH-1:0]    cpu_data_in,
  output logic                     cpu_rd,
  output logic [ADDR_WIDTH-1:0]    cpu_rd_addr,
  input  logic                     cpu_data_out_vld,
  input  logic [DATA_WIDTH-1:0]    cpu_data_out
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrRsp,
    StRdReq,
    StRdWait,
    StRdRsp
  } state_e;

  state_e                   state_q, state_d;

  // capture buffers
  logic                     aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0]    aw_addr_q, aw_addr_d;
  logic                     w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0]    w_data_q, w_data_d;
  logic [DATA_BYTE_NUM-1:0] w_strb_q, w_strb_d;
  logic                     ar_full_q, ar_full_d;
  logic [ADDR_WIDTH-1:0]    ar_addr_q, ar_addr_d;

  // registered channel outputs
  logic                     awready_q, awready_d;
  logic                     wready_q, wready_d;
  logic                     arready_q, arready_d;
  logic                     bvalid_q, bvalid_d;
  logic                     rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [1:0]               rresp_q, rresp_d;
  logic                     tmout_err_q, tmout_err_d;

  // registered HPI outputs
  logic                     cpu_wr_q, cpu_wr_d;
  logic [ADDR_WIDTH-1:0]    cpu_wr_addr_q, cpu_wr_addr_d;
  logic [DATA_BYTE_NUM-1:0] cpu_wr_strb_q, cpu_wr_strb_d;
  logic [DATA_WIDTH-1:0]    cpu_data_in_q, cpu_data_in_d;
  logic                     cpu_rd_q, cpu_rd_d;
  logic [ADDR_WIDTH-1:0]    cpu_rd_addr_q, cpu_rd_addr_d;

  logic [15:0]              tmout_cnt_q, tmout_cnt_d;
  logic [15:0]              tmout_cnt_inc;
  logic                     prio_wr_q, prio_wr_d;
  logic                     wr_elig, rd_elig;

  assign wr_elig       = aw_full_q & w_full_q;
  assign rd_elig       = ar_full_q;
  assign tmout_cnt_inc = tmout_cnt_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    aw_full_d     = aw_full_q;
    aw_addr_d     = aw_addr_q;
    w_full_d      = w_full_q;
    w_data_d      = w_data_q;
    w_strb_d      = w_strb_q;
    ar_full_d     = ar_full_q;
    ar_addr_d     = ar_addr_q;
    bvalid_d      = bvalid_q;
    rvalid_d      = rvalid_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    tmout_err_d   = 1'b0;
    cpu_wr_d      = 1'b0;
    cpu_wr_addr_d = cpu_wr_addr_q;
    cpu_wr_strb_d = cpu_wr_strb_q;
    cpu_data_in_d = cpu_data_in_q;
    cpu_rd_d      = 1'b0;
    cpu_rd_addr_d = cpu_rd_addr_q;
    tmout_cnt_d   = tmout_cnt_q;
    prio_wr_d     = prio_wr_q;

    // ready is low whenever the buffer is full, so a capture never overwrites
    if (awvalid && awready_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = awaddr;
    end
    if (wvalid && wready_q) begin
      w_full_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end
    if (arvalid && arready_q) begin
      ar_full_d = 1'b1;
      ar_addr_d = araddr;
    end

    case (state_q)
      StIdle: begin
        // pointer advances only on contested grants
        if (wr_elig && (!rd_elig || prio_wr_q)) begin
          state_d       = StWrReq;
          cpu_wr_d      = 1'b1;
          cpu_wr_addr_d = aw_addr_q;
          cpu_data_in_d = w_data_q;
          cpu_wr_strb_d = w_strb_q;
          if (rd_elig) prio_wr_d = 1'b0;
        end else if (rd_elig) begin
          state_d       = StRdReq;
          cpu_rd_d      = 1'b1;
          cpu_rd_addr_d = ar_addr_q;
          if (wr_elig) prio_wr_d = 1'b1;
        end
      end
      StWrReq: begin
        state_d  = StWrRsp;
        bvalid_d = 1'b1;
      end
      StWrRsp: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          state_d   = StIdle;
        end
      end
      StRdReq: begin
        tmout_cnt_d = '0;
        state_d     = StRdWait;
      end
      StRdWait: begin
        tmout_cnt_d = tmout_cnt_inc;
        if (cpu_data_out_vld) begin
          rdata_d  = cpu_data_out;
          rresp_d  = RespOkay;
          rvalid_d = 1'b1;
          state_d  = StRdRsp;
        end else if ((reg_tmout_cfg != 16'd0) && (tmout_cnt_inc == reg_tmout_cfg)) begin
          rdata_d     = '0;
          rresp_d     = RespSlverr;
          rvalid_d    = 1'b1;
          tmout_err_d = 1'b1;
          state_d     = StRdRsp;
        end
      end
      StRdRsp: begin
        if (rready) begin
          rvalid_d  = 1'b0;
          ar_full_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    awready_d = ~aw_full_d;
    wready_d  = ~w_full_d;
    arready_d = ~ar_full_d;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      aw_full_q     <= 1'b0;
      aw_addr_q     <= '0;
      w_full_q      <= 1'b0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      ar_full_q     <= 1'b0;
      ar_addr_q     <= '0;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      arready_q     <= 1'b0;
      bvalid_q      <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      rresp_q       <= RespOkay;
      tmout_err_q   <= 1'b0;
      cpu_wr_q      <= 1'b0;
      cpu_wr_addr_q <= '0;
      cpu_wr_strb_q <= '0;
      cpu_data_in_q <= '0;
      cpu_rd_q      <= 1'b0;
      cpu_rd_addr_q <= '0;
      tmout_cnt_q   <= '0;
      prio_wr_q     <= 1'b1;
    end else begin
      state_q       <= state_d;
      aw_full_q     <= aw_full_d;
      aw_addr_q     <= aw_addr_d;
      w_full_q      <= w_full_d;
      w_data_q      <= w_data_d;
      w_strb_q      <= w_strb_d;
      ar_full_q     <= ar_full_d;
      ar_addr_q     <= ar_addr_d;
      awready_q     <= awready_d;
      wready_q      <= wready_d;
      arready_q     <= arready_d;
      bvalid_q      <= bvalid_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      rresp_q       <= rresp_d;
      tmout_err_q   <= tmout_err_d;
      cpu_wr_q      <= cpu_wr_d;
      cpu_wr_addr_q <= cpu_wr_addr_d;
      cpu_wr_strb_q <= cpu_wr_strb_d;
      cpu_data_in_q <= cpu_data_in_d;
      cpu_rd_q      <= cpu_rd_d;
      cpu_rd_addr_q <= cpu_rd_addr_d;
      tmout_cnt_q   <= tmout_cnt_d;
      prio_wr_q     <= prio_wr_d;
    end
  end

  // HPI writes are posted, so every B response is OKAY
  assign bresp         = RespOkay;
  assign awready       = awready_q;
  assign wready        = wready_q;
  assign arready       = arready_q;
  assign bvalid        = bvalid_q;
  assign rvalid        = rvalid_q;
  assign rdata         = rdata_q;
  assign rresp         = rresp_q;
  assign reg_tmout_err = tmout_err_q;
  assign cpu_wr        = cpu_wr_q;
  assign cpu_wr_addr   = cpu_wr_addr_q;
  assign cpu_wr_strb   = cpu_wr_strb_q;
  assign cpu_data_in   = cpu_data_in_q;
  assign cpu_rd        = cpu_rd_q;
  assign cpu_rd_addr   = cpu_rd_addr_q;

endmodule

// File: tb/tb_axi4ls2hpi_adp.sv
// Scoreboard bench for axi4ls2hpi_adp: expectations queued at stimulus time,
// popped by negedge monitors on HPI strobes and B/R handshakes.
module tb_axi4ls2hpi_adp;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [15:0] reg_tmout_cfg;
  logic        reg_tmout_err;
  logic        cpu_wr, cpu_rd, cpu_data_out_vld;
  logic [31:0] cpu_wr_addr, cpu_data_in, cpu_rd_addr, cpu_data_out;
  logic [3:0]  cpu_wr_strb;

  axi4ls2hpi_adp #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_BYTE_NUM(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .reg_tmout_cfg(reg_tmout_cfg), .reg_tmout_err(reg_tmout_err),
    .cpu_wr(cpu_wr), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_strb(cpu_wr_strb),
    .cpu_data_in(cpu_data_in), .cpu_rd(cpu_rd), .cpu_rd_addr(cpu_rd_addr),
    .cpu_data_out_vld(cpu_data_out_vld), .cpu_data_out(cpu_data_out)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_exp_t;
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  wr_exp_t     exp_wr_q[$];
  logic [1:0]  exp_b_q[$];
  logic [31:0] exp_ra_q[$];
  rd_exp_t     exp_r_q[$];

  int n_checks = 0, n_errs = 0;
  int cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, b_cnt = 0, r_cnt = 0, err_cnt = 0;
  int wr_cyc = 0, rd_cyc = 0, bv_cyc = 0, rv_cyc = 0, err_cyc = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0;
  logic        rsp_en = 1'b0;
  int          rsp_delay = 1;
  logic [31:0] rsp_data = '0;
  int          stray_cnt = 0;
  logic        any_out;

  assign any_out = |{awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
                     reg_tmout_err, cpu_wr, cpu_wr_addr, cpu_wr_strb, cpu_data_in,
                     cpu_rd, cpu_rd_addr};

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitors: sample at negedge, inputs only change just after posedge.
  initial begin : mon
    wr_exp_t     e_wr;
    rd_exp_t     e_r;
    logic [1:0]  e_b;
    logic [31:0] e_ra;
    logic        bv_prev = 0, br_prev = 0, rv_prev = 0, rr_prev = 0;
    logic [31:0] rdata_prev = '0;
    logic [1:0]  rresp_prev = '0;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (cpu_wr || cpu_rd) check_eq("strobe_mutex", 64'(cpu_wr & cpu_rd), 64'd0);
        if (cpu_wr) begin
          check_eq("cpu_wr_expected", 64'(exp_wr_q.size() != 0), 64'd1);
          if (exp_wr_q.size() != 0) begin
            e_wr = exp_wr_q.pop_front();
            check_eq("cpu_wr_addr", 64'(cpu_wr_addr), 64'(e_wr.addr));
            check_eq("cpu_data_in", 64'(cpu_data_in), 64'(e_wr.data));
            check_eq("cpu_wr_strb", 64'(cpu_wr_strb), 64'(e_wr.strb));
          end
          wr_cnt++;
          wr_cyc = cyc;
        end
        if (cpu_rd) begin
          check_eq("cpu_rd_expected", 64'(exp_ra_q.size() != 0), 64'd1);
          if (exp_ra_q.size() != 0) begin
            e_ra = exp_ra_q.pop_front();
            check_eq("cpu_rd_addr", 64'(cpu_rd_addr), 64'(e_ra));
          end
          rd_cnt++;
          rd_cyc = cyc;
        end
        if (bvalid && bready) begin
          check_eq("b_expected", 64'(exp_b_q.size() != 0), 64'd1);
          if (exp_b_q.size() != 0) begin
            e_b = exp_b_q.pop_front();
            check_eq("bresp", 64'(bresp), 64'(e_b));
          end
          b_cnt++;
        end
        if (rvalid && rready) begin
          check_eq("r_expected", 64'(exp_r_q.size() != 0), 64'd1);
          if (exp_r_q.size() != 0) begin
            e_r = exp_r_q.pop_front();
            check_eq("rdata", 64'(rdata), 64'(e_r.data));
            check_eq("rresp", 64'(rresp), 64'(e_r.resp));
          end
          r_cnt++;
        end
        if (bvalid && !bv_prev) bv_cyc = cyc;
        if (rvalid && !rv_prev) rv_cyc = cyc;
        if (bv_prev && !br_prev) check_eq("bvalid_hold", 64'(bvalid), 64'd1);
        if (rv_prev && !rr_prev) begin
          check_eq("rvalid_hold", 64'(rvalid), 64'd1);
          check_eq("rdata_hold", 64'(rdata), 64'(rdata_prev));
          check_eq("rresp_hold", 64'(rresp), 64'(rresp_prev));
        end
        if (reg_tmout_err) begin
          err_cnt++;
          err_cyc = cyc;
        end
      end
      bv_prev    = aresetn & bvalid;
      br_prev    = bready;
      rv_prev    = aresetn & rvalid;
      rr_prev    = rready;
      rdata_prev = rdata;
      rresp_prev = rresp;
    end
  end

  // HPI register-file model: answers cpu_rd after rsp_delay cycles, or fires a stray return.
  initial begin : hpi
    int stray_done = 0;
    cpu_data_out_vld = 1'b0;
    cpu_data_out     = '0;
    forever begin
      @(negedge aclk);
      if (stray_cnt != stray_done) begin
        stray_done = stray_cnt;
        @(posedge aclk); #1;
        cpu_data_out_vld = 1'b1;
        cpu_data_out     = 32'hBAD0_BAD0;
        @(posedge aclk); #1;
        cpu_data_out_vld = 1'b0;
      end else if (cpu_rd && rsp_en && aresetn) begin
        repeat (rsp_delay) @(posedge aclk);
        #1;
        cpu_data_out_vld = 1'b1;
        cpu_data_out     = rsp_data;
        @(posedge aclk); #1;
        cpu_data_out_vld = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errs);
    $fatal(1, "watchdog expired");
  end

  task automatic sync();
    @(posedge aclk); #1;
  endtask

  task automatic send_aw(input logic [31:0] a, output int hs);
    int n = 0;
    awvalid = 1'b1; awaddr = a;
    @(negedge aclk);
    while (!awready && n < 100) begin @(negedge aclk); n++; end
    check_eq("aw_handshake", 64'(awready), 64'd1);
    hs = cyc;
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, output int hs);
    int n = 0;
    wvalid = 1'b1; wdata = d; wstrb = s;
    @(negedge aclk);
    while (!wready && n < 100) begin @(negedge aclk); n++; end
    check_eq("w_handshake", 64'(wready), 64'd1);
    hs = cyc;
    @(posedge aclk); #1;
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, output int hs);
    int n = 0;
    arvalid = 1'b1; araddr = a;
    @(negedge aclk);
    while (!arready && n < 100) begin @(negedge aclk); n++; end
    check_eq("ar_handshake", 64'(arready), 64'd1);
    hs = cyc;
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_b(input int target);
    int n = 0;
    while (b_cnt < target && n < 200) begin @(negedge aclk); #2; n++; end
    check_eq("b_arrive", 64'(b_cnt >= target), 64'd1);
  endtask

  task automatic wait_r(input int target);
    int n = 0;
    while (r_cnt < target && n < 200) begin @(negedge aclk); #2; n++; end
    check_eq("r_arrive", 64'(r_cnt >= target), 64'd1);
  endtask

  task automatic wait_rd(input int target);
    int n = 0;
    while (rd_cnt < target && n < 200) begin @(negedge aclk); #2; n++; end
    check_eq("cpu_rd_arrive", 64'(rd_cnt >= target), 64'd1);
  endtask

  task automatic wait_sig(input string tag, input bit want_b);
    int n = 0;
    while (!(want_b ? bvalid : rvalid) && n < 100) begin @(negedge aclk); #2; n++; end
    check_eq(tag, 64'(want_b ? bvalid : rvalid), 64'd1);
  endtask

  task automatic arb_round(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra,
                           input int nb, input int nr, input bit wr_first);
    int hs_a, hs_w, hs_r;
    rsp_en = 1'b1; rsp_delay = 2; rsp_data = ra ^ 32'hC0DE_0000;
    sync();
    exp_wr_q.push_back(wr_exp_t'{addr: wa, data: wd, strb: 4'hF});
    exp_b_q.push_back(2'b00);
    exp_ra_q.push_back(ra);
    exp_r_q.push_back(rd_exp_t'{data: ra ^ 32'hC0DE_0000, resp: 2'b00});
    fork
      send_aw(wa, hs_a);
      send_w(wd, 4'hF, hs_w);
      send_ar(ra, hs_r);
    join
    wait_b(nb);
    wait_r(nr);
    check_eq("arb_tie", 64'(hs_a), 64'(hs_r));
    if (wr_first) begin
      check_eq("arb_wr_first_lat", 64'(wr_cyc), 64'(hs_a + 2));
      check_eq("arb_wr_before_rd", 64'(wr_cyc < rd_cyc), 64'd1);
    end else begin
      check_eq("arb_rd_first_lat", 64'(rd_cyc), 64'(hs_r + 2));
      check_eq("arb_rd_before_wr", 64'(rd_cyc < wr_cyc), 64'd1);
    end
  endtask

  initial begin : main
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; reg_tmout_cfg = '0;

    // reset state
    repeat (3) @(negedge aclk);
    check_eq("rst_outputs", 64'(any_out), 64'd0);
    #2 aresetn = 1'b1;
    check_eq("rst_awready_still_low", 64'(awready), 64'd0);
    @(negedge aclk);
    check_eq("readies_after_rst", 64'({awready, wready, arready}), 64'b111);

    // basic write
    sync();
    exp_wr_q.push_back(wr_exp_t'{addr: 32'h10, data: 32'hA5A5_0001, strb: 4'hF});
    exp_b_q.push_back(2'b00);
    fork
      send_aw(32'h10, aw_hs);
      send_w(32'hA5A5_0001, 4'hF, w_hs);
    join
    wait_b(1);
    check_eq("wr_strobe_lat", 64'(wr_cyc), 64'(aw_hs + 2));
    check_eq("bvalid_lat", 64'(bv_cyc), 64'(aw_hs + 3));
    check_eq("awready_low_at_b", 64'(awready), 64'd0);
    @(negedge aclk);
    check_eq("readies_after_b", 64'({awready, wready}), 64'b11);

    // W well ahead of AW, B back-pressured
    bready = 1'b0;
    sync();
    exp_wr_q.push_back(wr_exp_t'{addr: 32'h44, data: 32'hDEAD_BEEF, strb: 4'b0101});
    exp_b_q.push_back(2'b00);
    fork
      send_w(32'hDEAD_BEEF, 4'b0101, w_hs);
      begin
        repeat (5) sync();
        send_aw(32'h44, aw_hs);
      end
    join
    wait_sig("bvalid_arrive", 1'b1);
    check_eq("w_before_aw", 64'(aw_hs - w_hs), 64'd5);
    check_eq("indep_wr_lat", 64'(wr_cyc), 64'(aw_hs + 2));
    check_eq("indep_bvalid_lat", 64'(bv_cyc), 64'(aw_hs + 3));
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check_eq("bvalid_stall", 64'(bvalid), 64'd1);
      check_eq("readies_stall", 64'({awready, wready}), 64'b00);
    end
    sync();
    bready = 1'b1;
    wait_b(2);
    @(negedge aclk);
    check_eq("readies_after_b2", 64'({awready, wready}), 64'b11);

    // read with data, R back-pressured
    rready = 1'b0; rsp_en = 1'b1; rsp_delay = 3; rsp_data = 32'h1234_5678;
    sync();
    exp_ra_q.push_back(32'h20);
    exp_r_q.push_back(rd_exp_t'{data: 32'h1234_5678, resp: 2'b00});
    send_ar(32'h20, ar_hs);
    wait_rd(1);
    check_eq("rd_strobe_lat", 64'(rd_cyc), 64'(ar_hs + 2));
    wait_sig("rvalid_arrive", 1'b0);
    check_eq("rvalid_lat", 64'(rv_cyc), 64'(rd_cyc + 4));
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check_eq("rvalid_stall", 64'(rvalid), 64'd1);
      check_eq("rdata_stall", 64'(rdata), 64'h1234_5678);
    end
    sync();
    rready = 1'b1;
    wait_r(1);

    // read timeout, then a stray late return
    rsp_en = 1'b0; reg_tmout_cfg = 16'd8;
    sync();
    exp_ra_q.push_back(32'h30);
    exp_r_q.push_back(rd_exp_t'{data: 32'h0, resp: 2'b10});
    send_ar(32'h30, ar_hs);
    wait_rd(2);
    wait_r(2);
    check_eq("tmout_rvalid_lat", 64'(rv_cyc), 64'(rd_cyc + 9));
    check_eq("tmout_err_count", 64'(err_cnt), 64'd1);
    check_eq("tmout_err_when", 64'(err_cyc), 64'(rv_cyc));
    sync();
    stray_cnt++;
    repeat (6) @(negedge aclk);
    check_eq("stray_no_r", 64'(r_cnt), 64'd2);
    check_eq("stray_rvalid", 64'(rvalid), 64'd0);
    check_eq("stray_no_err", 64'(err_cnt), 64'd1);

    // arbitration: two ties in a row
    arb_round(32'h100, 32'h1111_0000, 32'h200, 3, 3, 1'b1);
    arb_round(32'h104, 32'h2222_0000, 32'h204, 4, 4, 1'b0);

    // reset abort during RD_WAIT
    reg_tmout_cfg = 16'd0; rsp_en = 1'b0;
    sync();
    exp_ra_q.push_back(32'h300);
    send_ar(32'h300, ar_hs);
    wait_rd(5);
    sync();
    sync();
    aresetn = 1'b0;
    #1;
    check_eq("abort_outputs", 64'(any_out), 64'd0);
    @(negedge aclk);
    #2 aresetn = 1'b1;
    check_eq("abort_readies_low", 64'({awready, wready, arready}), 64'b000);
    @(negedge aclk);
    check_eq("abort_readies_up", 64'({awready, wready, arready}), 64'b111);

    rsp_en = 1'b1; rsp_delay = 1; rsp_data = 32'h0BAD_F00D;
    sync();
    exp_ra_q.push_back(32'h304);
    exp_r_q.push_back(rd_exp_t'{data: 32'h0BAD_F00D, resp: 2'b00});
    send_ar(32'h304, ar_hs);
    wait_rd(6);
    wait_r(5);
    check_eq("post_abort_rd_lat", 64'(rd_cyc), 64'(ar_hs + 2));
    check_eq("post_abort_rvalid_lat", 64'(rv_cyc), 64'(rd_cyc + 2));

    repeat (3) @(negedge aclk);
    check_eq("left_wr", 64'(exp_wr_q.size()), 64'd0);
    check_eq("left_b", 64'(exp_b_q.size()), 64'd0);
    check_eq("left_ra", 64'(exp_ra_q.size()), 64'd0);
    check_eq("left_r", 64'(exp_r_q.size()), 64'd0);
    check_eq("total_tmout_err", 64'(err_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
